// File: rtl/vps_pkg.sv
// vps_pkg: shared types and constants for the video pattern source.
//   state_t  - frame sequencer states
//   mode_t   - test pattern selector
//   REG_*    - Avalon-MM word addresses of the configuration registers
//   HDR_*    - Avalon-ST video packet type identifiers
//   bar_colour() - colour bar lookup, bar 0 is leftmost
package vps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_VHDR,
    ST_PIX,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_CHECK = 2'd3
  } mode_t;

  localparam logic [3:0] REG_ENABLE    = 4'd0;
  localparam logic [3:0] REG_MODE      = 4'd1;
  localparam logic [3:0] REG_COLOUR    = 4'd2;
  localparam logic [3:0] REG_FRAME_CNT = 4'd3;

  localparam logic [3:0] HDR_CTRL  = 4'hF;
  localparam logic [3:0] HDR_VIDEO = 4'h0;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/vps_if.sv
// Bus interfaces of the video pattern source.
//   vps_st_if : Avalon-ST video stream (ready latency 0)
//     source_data[23:0], source_valid, source_sop, source_eop : source -> sink
//     source_ready                                             : sink -> source
//     modports: src (pattern source side), snk (downstream side)
//   vps_mm_if : Avalon-MM configuration slave bus
//     s_chipselect, s_read, s_write, s_address[3:0], s_writedata[31:0] : master -> slave
//     s_readdata[31:0] (registered, 1-cycle latency)                  : slave -> master
//     modports: master, slave
interface vps_st_if;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;

  modport src (output source_data, source_valid, source_sop, source_eop,
               input  source_ready);
  modport snk (input  source_data, source_valid, source_sop, source_eop,
               output source_ready);
endinterface

interface vps_mm_if;
  logic        s_chipselect;
  logic        s_read;
  logic        s_write;
  logic [3:0]  s_address;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;

  modport master (output s_chipselect, s_read, s_write, s_address, s_writedata,
                  input  s_readdata);
  modport slave  (input  s_chipselect, s_read, s_write, s_address, s_writedata,
                  output s_readdata);
endinterface

// File: rtl/vps_pattern_gen.sv
// vps_pattern_gen: combinational test pattern generator.
//   x_i, y_i  [11:0] current pixel position
//   mode_i           pattern select (bars / gradient / solid / checker)
//   colour_i  [23:0] solid colour
//   pixel_o   [23:0] {R,G,B}
// Build option VPS_CROSSHAIR_EN: when defined, the centre column and centre
// row are painted red over every pattern (adds the IMG_H parameter).
module vps_pattern_gen
  import vps_pkg::*;
#(
  parameter int IMG_W = 640
`ifdef VPS_CROSSHAIR_EN
  , parameter int IMG_H = 480
`endif
) (
  input  logic [11:0] x_i,
  input  logic [11:0] y_i,
  input  mode_t       mode_i,
  input  logic [23:0] colour_i,
  output logic [23:0] pixel_o
);

  // Narrow images still get one-pixel bars instead of a divide by zero.
  localparam int         BAR_W   = (IMG_W / 8 > 0) ? IMG_W / 8 : 1;
  localparam logic [11:0] BAR_DIV = 12'(BAR_W);
`ifdef VPS_CROSSHAIR_EN
  localparam logic [11:0] CROSS_X = 12'(IMG_W / 2);
  localparam logic [11:0] CROSS_Y = 12'(IMG_H / 2);
`endif

  logic [11:0] bar_idx;
  logic        unused_y;

  assign unused_y = ^y_i;

  always_comb begin
    bar_idx = x_i / BAR_DIV;
    pixel_o = 24'h000000;
    case (mode_i)
      // Last bar absorbs the remainder when IMG_W is not a multiple of 8.
      MODE_BARS:  pixel_o = bar_colour((bar_idx > 12'd7) ? 3'd7 : bar_idx[2:0]);
      MODE_GRAD:  pixel_o = {3{x_i[7:0]}};
      MODE_SOLID: pixel_o = colour_i;
      MODE_CHECK: pixel_o = (x_i[3] ^ y_i[3]) ? 24'hFFFFFF : 24'h000000;
      default:    pixel_o = 24'h000000;
    endcase
`ifdef VPS_CROSSHAIR_EN
    if (x_i == CROSS_X || y_i == CROSS_Y) pixel_o = 24'hFF0000;
`endif
  end

endmodule

// File: rtl/video_pattern_source.sv
// video_pattern_source: Avalon-ST video transmitter producing test patterns.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   st_if    Avalon-ST source: control packet, video packet (24b RGB)
//   mm_if    Avalon-MM slave: 0 ENABLE, 1 MODE, 2 COLOUR, 3 FRAME_CNT (ro)
// Build option VPS_CROSSHAIR_EN: red crosshair overlay (see vps_pattern_gen).
//
// state | meaning
// IDLE  | no output, waiting for ENABLE
// CTRL  | 4-beat control packet carrying width/height/interlace nibbles
// VHDR  | video packet header beat (sop)
// PIX   | IMG_W*IMG_H pixels in raster order, eop on the last
// GAP   | FRAME_GAP idle cycles, then next frame or IDLE
module video_pattern_source
  import vps_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int FRAME_GAP = 16   // must be >= 1
) (
  input  logic     clk,
  input  logic     reset_n,
  vps_st_if.src    st_if,
  vps_mm_if.slave  mm_if
);

  localparam logic [15:0] W16      = 16'(IMG_W);
  localparam logic [15:0] H16      = 16'(IMG_H);
  localparam logic [11:0] X_LAST   = 12'(IMG_W - 1);
  localparam logic [11:0] Y_LAST   = 12'(IMG_H - 1);
  localparam logic [15:0] GAP_LOAD = 16'(FRAME_GAP - 1);

  // configuration registers
  logic        enable_q;
  mode_t       mode_q;
  logic [23:0] colour_q;
  logic [31:0] frame_cnt_q;
  logic [31:0] readdata_q;
  logic [31:0] rd_mux;
  logic        mm_rd, mm_wr;
  logic        unused_wdata;

  // sequencer
  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [15:0] gap_q, gap_d;
  mode_t       mode_sh_q, mode_sh_d;
  logic [23:0] colour_sh_q, colour_sh_d;
  logic        frame_done;

  // output register and next beat
  logic        valid_q, sop_q, eop_q;
  logic [23:0] data_q;
  logic        gen_valid, gen_sop, gen_eop;
  logic [23:0] gen_data;
  logic        load;
  logic [23:0] pixel;

  // A read in the same cycle as a write wins; the write is dropped.
  assign mm_rd        = mm_if.s_chipselect && mm_if.s_read;
  assign mm_wr        = mm_if.s_chipselect && mm_if.s_write && !mm_if.s_read;
  assign unused_wdata = ^mm_if.s_writedata[31:24];

  always_comb begin
    case (mm_if.s_address)
      REG_ENABLE:    rd_mux = {31'd0, enable_q};
      REG_MODE:      rd_mux = {30'd0, mode_q};
      REG_COLOUR:    rd_mux = {8'd0, colour_q};
      REG_FRAME_CNT: rd_mux = frame_cnt_q;
      default:       rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q    <= 1'b0;
      mode_q      <= MODE_BARS;
      colour_q    <= 24'd0;
      frame_cnt_q <= 32'd0;
      readdata_q  <= 32'd0;
    end else begin
      if (mm_wr) begin
        case (mm_if.s_address)
          REG_ENABLE: enable_q <= mm_if.s_writedata[0];
          REG_MODE:   mode_q   <= mode_t'(mm_if.s_writedata[1:0]);
          REG_COLOUR: colour_q <= mm_if.s_writedata[23:0];
          default:    ;
        endcase
      end
      if (mm_rd) readdata_q <= rd_mux;
      if (frame_done) frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  assign mm_if.s_readdata = readdata_q;

  vps_pattern_gen #(
    .IMG_W (IMG_W)
`ifdef VPS_CROSSHAIR_EN
    , .IMG_H (IMG_H)
`endif
  ) u_pattern_gen (
    .x_i      (x_q),
    .y_i      (y_q),
    .mode_i   (mode_sh_q),
    .colour_i (colour_sh_q),
    .pixel_o  (pixel)
  );

  // The FSM describes the beat that would be loaded next; it only advances
  // when the output register accepts that beat.
  assign load = !valid_q || st_if.source_ready;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    x_d         = x_q;
    y_d         = y_q;
    gap_d       = gap_q;
    mode_sh_d   = mode_sh_q;
    colour_sh_d = colour_sh_q;
    frame_done  = 1'b0;
    gen_valid   = 1'b0;
    gen_sop     = 1'b0;
    gen_eop     = 1'b0;
    gen_data    = 24'd0;

    case (state_q)
      ST_IDLE: begin
        if (enable_q) begin
          state_d     = ST_CTRL;
          beat_d      = 2'd0;
          mode_sh_d   = mode_q;
          colour_sh_d = colour_q;
        end
      end
      ST_CTRL: begin
        gen_valid = 1'b1;
        case (beat_q)
          2'd0: begin
            gen_data = {20'd0, HDR_CTRL};
            gen_sop  = 1'b1;
          end
          2'd1: gen_data = {4'd0, W16[7:4], 4'd0, W16[11:8], 4'd0, W16[15:12]};
          2'd2: gen_data = {4'd0, H16[11:8], 4'd0, H16[15:12], 4'd0, W16[3:0]};
          default: begin
            gen_data = {4'd0, 4'h3, 4'd0, H16[3:0], 4'd0, H16[7:4]};
            gen_eop  = 1'b1;
          end
        endcase
        if (load) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = ST_VHDR;
        end
      end
      ST_VHDR: begin
        gen_valid = 1'b1;
        gen_sop   = 1'b1;
        gen_data  = {20'd0, HDR_VIDEO};
        if (load) begin
          state_d = ST_PIX;
          x_d     = 12'd0;
          y_d     = 12'd0;
        end
      end
      ST_PIX: begin
        gen_valid = 1'b1;
        gen_data  = pixel;
        gen_eop   = (x_q == X_LAST) && (y_q == Y_LAST);
        if (load) begin
          if (x_q == X_LAST) begin
            x_d = 12'd0;
            y_d = y_q + 12'd1;
            if (y_q == Y_LAST) begin
              y_d        = 12'd0;
              state_d    = ST_GAP;
              gap_d      = GAP_LOAD;
              frame_done = 1'b1;
            end
          end else begin
            x_d = x_q + 12'd1;
          end
        end
      end
      ST_GAP: begin
        if (load) begin
          if (gap_q == 16'd0) begin
            if (enable_q) begin
              state_d     = ST_CTRL;
              beat_d      = 2'd0;
              mode_sh_d   = mode_q;
              colour_sh_d = colour_q;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            gap_d = gap_q - 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= 2'd0;
      x_q         <= 12'd0;
      y_q         <= 12'd0;
      gap_q       <= 16'd0;
      mode_sh_q   <= MODE_BARS;
      colour_sh_q <= 24'd0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= 24'd0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      x_q         <= x_d;
      y_q         <= y_d;
      gap_q       <= gap_d;
      mode_sh_q   <= mode_sh_d;
      colour_sh_q <= colour_sh_d;
      if (load) begin
        valid_q <= gen_valid;
        sop_q   <= gen_sop;
        eop_q   <= gen_eop;
        data_q  <= gen_data;
      end
    end
  end

  assign st_if.source_valid = valid_q;
  assign st_if.source_sop   = sop_q;
  assign st_if.source_eop   = eop_q;
  assign st_if.source_data  = data_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Bench for video_pattern_source: an 8x4 instance (a) exercises the stream,
// registers, stalls, disable and reset; a 16x16 instance (b) covers the
// checkerboard. Expected beats come from a frame model built from the pattern
// rules and are queued per instance; monitors pop and compare accepted beats.
module tb_video_pattern_source;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [23:0] data;
  } beat_t;

  localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs_a, cs_b, rd, wr;
  logic [3:0]  addr;
  logic [31:0] wdata;
  bit          rand_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  int acc_a = 0;
  int exp_fc = 0;

  beat_t qa[$];
  beat_t qb[$];

  vps_st_if st_a ();
  vps_st_if st_b ();
  vps_mm_if mm_a ();
  vps_mm_if mm_b ();

  assign mm_a.s_chipselect = cs_a;
  assign mm_a.s_read       = rd;
  assign mm_a.s_write      = wr;
  assign mm_a.s_address    = addr;
  assign mm_a.s_writedata  = wdata;
  assign mm_b.s_chipselect = cs_b;
  assign mm_b.s_read       = rd;
  assign mm_b.s_write      = wr;
  assign mm_b.s_address    = addr;
  assign mm_b.s_writedata  = wdata;
  assign st_b.source_ready = 1'b1;

  video_pattern_source #(.IMG_W(8), .IMG_H(4), .FRAME_GAP(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .st_if   (st_a),
    .mm_if   (mm_a)
  );

  video_pattern_source #(.IMG_W(16), .IMG_H(16), .FRAME_GAP(2)) dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .st_if   (st_b),
    .mm_if   (mm_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    st_a.source_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [23:0] ref_pixel(input int x, input int y, input int w, input int h,
                                            input int mode, input logic [23:0] col);
    int bar;
    logic [23:0] p;
    case (mode)
      0: begin
        bar = x / (w / 8);
        if (bar > 7) bar = 7;
        p = BARS[bar];
      end
      1: p = {3{8'(x % 256)}};
      2: p = col;
      default: p = (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
    endcase
`ifdef VPS_CROSSHAIR_EN
    if (x == w / 2 || y == h / 2) p = 24'hFF0000;
`else
    if (h < 0) p = 24'h0;
`endif
    return p;
  endfunction

  // Control beat carries three nibbles at bit offsets 0, 8 and 16.
  function automatic logic [23:0] nib3(input int n0, input int n1, input int n2);
    return 24'(n0 % 16) | (24'(n1 % 16) << 8) | (24'(n2 % 16) << 16);
  endfunction

  function automatic beat_t mk(input logic sop, input logic eop, input logic [23:0] d);
    beat_t b;
    b.sop = sop; b.eop = eop; b.data = d;
    return b;
  endfunction

  task automatic push_frame(input bit to_b, input int w, input int h, input int mode,
                            input logic [23:0] col);
    beat_t f[$];
    f.push_back(mk(1'b1, 1'b0, 24'h00000F));
    f.push_back(mk(1'b0, 1'b0, nib3(w / 4096, w / 256, w / 16)));
    f.push_back(mk(1'b0, 1'b0, nib3(w, h / 4096, h / 256)));
    f.push_back(mk(1'b0, 1'b1, nib3(h / 16, h, 3)));
    f.push_back(mk(1'b1, 1'b0, 24'h000000));
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        f.push_back(mk(1'b0, (x == w - 1 && y == h - 1), ref_pixel(x, y, w, h, mode, col)));
    foreach (f[i]) begin
      if (to_b) qb.push_back(f[i]);
      else qa.push_back(f[i]);
    end
  endtask

  // ---------------- monitors ----------------
  beat_t a_prev;
  bit    a_stalled = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    if (!reset_n) begin
      a_stalled = 1'b0;
    end else begin
      if (a_stalled)
        check("stall_hold_a", {6'd0, st_a.source_valid, st_a.source_sop, st_a.source_eop, st_a.source_data},
              {6'd0, 1'b1, a_prev});
      if (st_a.source_valid && st_a.source_ready) begin
        acc_a++;
        if (qa.size() == 0) begin
          check("unexpected_beat_a", {7'd0, st_a.source_sop, st_a.source_eop, st_a.source_data}, 32'hFFFF_FFFF);
        end else begin
          e = qa.pop_front();
          check("beat_a", {6'd0, st_a.source_sop, st_a.source_eop, st_a.source_data}, {6'd0, e});
        end
      end
      a_stalled = st_a.source_valid && !st_a.source_ready;
      a_prev    = {st_a.source_sop, st_a.source_eop, st_a.source_data};
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (reset_n && st_b.source_valid && st_b.source_ready) begin
      if (qb.size() == 0) begin
        check("unexpected_beat_b", {7'd0, st_b.source_sop, st_b.source_eop, st_b.source_data}, 32'hFFFF_FFFF);
      end else begin
        e = qb.pop_front();
        check("beat_b", {6'd0, st_b.source_sop, st_b.source_eop, st_b.source_data}, {6'd0, e});
      end
    end
  end

  // ---------------- MM helpers ----------------
  task automatic mm_write(input bit to_b, input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cs_a = !to_b; cs_b = to_b; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    cs_a = 1'b0; cs_b = 1'b0; wr = 1'b0;
  endtask

  task automatic mm_read(input bit from_b, input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    cs_a = !from_b; cs_b = from_b; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    cs_a = 1'b0; cs_b = 1'b0; rd = 1'b0;
    d = from_b ? mm_b.s_readdata : mm_a.s_readdata;
  endtask

  task automatic read_check(input bit from_b, input logic [3:0] a, input logic [31:0] exp,
                            input string name);
    logic [31:0] d;
    mm_read(from_b, a, d);
    check(name, d, exp);
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int n = 0;
    while (acc_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(acc_a >= target), 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(qa.size() + qb.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // ENABLE is high for only a couple of cycles, so exactly one frame is sent.
  task automatic one_frame(input bit to_b, input int mode, input logic [23:0] col,
                           input int w, input int h);
    mm_write(to_b, 4'd1, 32'(mode));
    mm_write(to_b, 4'd2, {8'd0, col});
    push_frame(to_b, w, h, mode, col);
    mm_write(to_b, 4'd0, 32'd1);
    mm_write(to_b, 4'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    bit seen;
    logic [23:0] col;

    reset_n = 1'b0;
    cs_a = 1'b0; cs_b = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_valid", {31'd0, st_a.source_valid}, 32'd0);
    check("rst_sop_eop", {30'd0, st_a.source_sop, st_a.source_eop}, 32'd0);
    check("rst_data", {8'd0, st_a.source_data}, 32'd0);
    check("rst_readdata", mm_a.s_readdata, 32'd0);
    read_check(1'b0, 4'd0, 32'd0, "rst_enable");
    read_check(1'b0, 4'd1, 32'd0, "rst_mode");
    read_check(1'b0, 4'd2, 32'd0, "rst_colour");
    read_check(1'b0, 4'd3, 32'd0, "rst_frame_cnt");

    // bars, full-rate ready
    one_frame(1'b0, 0, 24'h0, 8, 4);
    wait_drain(400, "drain_bars");
    exp_fc++;
    read_check(1'b0, 4'd3, 32'(exp_fc), "frame_cnt_1");

    // solid and gradient under random backpressure
    rand_ready = 1'b1;
    col = 24'($urandom);
    one_frame(1'b0, 2, col, 8, 4);
    wait_drain(800, "drain_solid");
    exp_fc++;
    read_check(1'b0, 4'd2, {8'd0, col}, "colour_rb");
    one_frame(1'b0, 1, 24'($urandom), 8, 4);
    wait_drain(800, "drain_grad");
    exp_fc++;

    // continuous run: MODE change mid-frame lands next frame; disable at pixel 10
    base = acc_a;
    mm_write(1'b0, 4'd1, 32'd0);
    push_frame(1'b0, 8, 4, 0, 24'h0);
    push_frame(1'b0, 8, 4, 1, 24'h0);
    mm_write(1'b0, 4'd0, 32'd1);
    wait_acc(base + 15, 800, "reach_f1_px10");
    mm_write(1'b0, 4'd1, 32'd1);
    wait_acc(base + 37 + 15, 800, "reach_f2_px10");
    mm_write(1'b0, 4'd0, 32'd0);
    wait_drain(800, "drain_multi");
    exp_fc += 2;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (st_a.source_valid) seen = 1'b1;
    end
    check("idle_after_disable", {31'd0, seen}, 32'd0);
    read_check(1'b0, 4'd3, 32'(exp_fc), "frame_cnt_multi");

    // register corner cases
    @(posedge clk); #1;
    cs_a = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'd1; wdata = 32'd3;
    @(posedge clk); #1;
    cs_a = 1'b0; rd = 1'b0; wr = 1'b0;
    check("rw_collide_rdata", mm_a.s_readdata, 32'd1);
    read_check(1'b0, 4'd1, 32'd1, "rw_collide_mode");
    mm_write(1'b0, 4'd3, 32'hDEAD_BEEF);
    read_check(1'b0, 4'd3, 32'(exp_fc), "frame_cnt_ro");
    read_check(1'b0, 4'd9, 32'd0, "unmapped_read");

    // reset in the middle of the pixel payload
    rand_ready = 1'b0;
    base = acc_a;
    mm_write(1'b0, 4'd1, 32'd3);
    push_frame(1'b0, 8, 4, 3, 24'h0);
    mm_write(1'b0, 4'd0, 32'd1);
    wait_acc(base + 15, 400, "reach_rst_point");
    @(posedge clk); #1;
    check("pre_reset_valid", {31'd0, st_a.source_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_valid_drop", {31'd0, st_a.source_valid}, 32'd0);
    check("reset_readdata", mm_a.s_readdata, 32'd0);
    qa.delete();
    exp_fc = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    read_check(1'b0, 4'd0, 32'd0, "post_rst_enable");
    read_check(1'b0, 4'd1, 32'd0, "post_rst_mode");
    read_check(1'b0, 4'd2, 32'd0, "post_rst_colour");
    read_check(1'b0, 4'd3, 32'd0, "post_rst_frame_cnt");
    one_frame(1'b0, 0, 24'h0, 8, 4);
    wait_drain(400, "drain_after_reset");
    exp_fc++;
    read_check(1'b0, 4'd3, 32'(exp_fc), "frame_cnt_after_reset");

    // checkerboard on the 16x16 instance
    one_frame(1'b1, 3, 24'h0, 16, 16);
    wait_drain(1000, "drain_check16");
    read_check(1'b1, 4'd3, 32'd1, "frame_cnt_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
